// File: rtl/oled_spi_timer.sv
// OLED support core: a saturating delay timer and a byte-serial mode-3 SPI transmitter
// sending 1-3 bytes (byte0 first, MSB first) under a level send/rdy handshake.
module oled_spi_timer #(
  parameter int SCLK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [31:0] N,
  output logic        t,
  input  logic [1:0]  numbytes,
  input  logic [23:0] cmd,
  input  logic        send,
  output logic        rdy,
  output logic        sclk,
  output logic        sdo,
  output logic        cs_n
);

  localparam int PW = $clog2(SCLK_DIV) + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  logic [31:0]   cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [23:0]   cmd_q, cmd_d;
  logic [1:0]    nb_q, nb_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          rdy_q, rdy_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          sdo_q, sdo_d;
  logic [4:0]    next_bit_s;
  logic [4:0]    next_byte_s;

  // Timer next count: clear, count up, or saturate at N.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 32'd0;
    end else if (cnt_q < N) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Expiry is combinational on clr so clearing drops t within the same cycle.
  assign t = !rst && !clr && (cnt_q >= N);

  assign next_bit_s  = {byte_idx_q, bit_idx_q - 3'd1};
  assign next_byte_s = {byte_idx_q + 2'd1, 3'd7};

  // SPI next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    nb_d       = nb_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    phase_d    = phase_q;
    rdy_d      = rdy_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    case (state_q)
      S_IDLE: begin
        if (!rdy_q) begin
          // Tail of a zero-byte request: one cycle of rdy low, then idle again.
          rdy_d = 1'b1;
        end else if (send) begin
          cmd_d = cmd;
          nb_d  = numbytes;
          rdy_d = 1'b0;
          if (numbytes != 2'd0) begin
            state_d    = S_LOW;
            cs_n_d     = 1'b0;
            sclk_d     = 1'b0;
            sdo_d      = cmd[7];
            bit_idx_d  = 3'd7;
            byte_idx_d = 2'd0;
            phase_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOW: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      S_HIGH: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
            sdo_d     = cmd_q[next_bit_s];
            sclk_d    = 1'b0;
            state_d   = S_LOW;
          end else if (byte_idx_q != (nb_q - 2'd1)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = 3'd7;
            sdo_d      = cmd_q[next_byte_s];
            sclk_d     = 1'b0;
            state_d    = S_LOW;
          end else begin
            state_d = S_IDLE;
            cs_n_d  = 1'b1;
            rdy_d   = 1'b1;
            sdo_d   = 1'b0;
          end
        end else begin
          phase_d = phase_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        sdo_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 32'd0;
      state_q    <= S_IDLE;
      cmd_q      <= 24'd0;
      nb_q       <= 2'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      phase_q    <= '0;
      rdy_q      <= 1'b1;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      sdo_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      nb_q       <= nb_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      phase_q    <= phase_d;
      rdy_q      <= rdy_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
    end
  end

  assign rdy  = rdy_q;
  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign sdo  = sdo_q;

endmodule

// File: tb/tb_oled_spi_timer.sv
// Randomized bench for oled_spi_timer: timer checked against an elapsed-cycles model,
// SPI checked by decoding the serial line back into bytes and timing cs_n.
module tb_oled_spi_timer;

  localparam int DIV = 2;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [31:0] N;
  logic        t;
  logic [1:0]  numbytes;
  logic [23:0] cmd;
  logic        send;
  logic        rdy;
  logic        sclk;
  logic        sdo;
  logic        cs_n;

  int n_chk;
  int n_pass;
  int lo_cnt;
  int rises;
  logic rx_bits[$];

  oled_spi_timer #(.SCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .clr(clr), .N(N), .t(t),
    .numbytes(numbytes), .cmd(cmd), .send(send),
    .rdy(rdy), .sclk(sclk), .sdo(sdo), .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver side: capture data on sclk rising edges, time cs_n on falling clk edges.
  always @(posedge sclk) begin
    rises = rises + 1;
    if (cs_n === 1'b0) rx_bits.push_back(sdo);
  end

  always @(negedge clk) begin
    if (cs_n === 1'b0) lo_cnt = lo_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_bits.delete();
    lo_cnt = 0;
    rises  = 0;
  endtask

  task automatic start_xfer(input int nb, input logic [23:0] c);
    chk("rdy_idle", rdy, 1);
    send     = 1'b1;
    cmd      = c;
    numbytes = nb[1:0];
    clear_mon();
    tick();
    chk("start_rdy", rdy, 0);
    chk("start_cs_n", cs_n, 0);
    chk("start_sclk", sclk, 0);
    chk("start_sdo", sdo, c[7]);
  endtask

  task automatic finish_xfer(input int nb, input logic [23:0] c, input bit hold,
                             input logic [23:0] c2, input logic [1:0] nb2);
    int n;
    logic [7:0] b;
    n = 0;
    if (hold) begin
      cmd      = c2;
      numbytes = nb2;
    end else begin
      send     = 1'b0;
      cmd      = 24'($urandom);
      numbytes = 2'($urandom);
    end
    while (rdy !== 1'b1 && n < 200) begin
      tick();
      n = n + 1;
    end
    chk("xfer_cycles", n, 16 * DIV * nb);
    chk("cs_low_cycles", lo_cnt, 16 * DIV * nb);
    chk("sclk_rises", rises, 8 * nb);
    chk("end_cs_n", cs_n, 1);
    chk("end_sclk", sclk, 1);
    chk("end_sdo", sdo, 0);
    for (int i = 0; i < nb; i++) begin
      b = 8'd0;
      for (int j = 0; j < 8; j++) begin
        if (8 * i + j < rx_bits.size()) b = {b[6:0], rx_bits[8 * i + j]};
        else b = {b[6:0], 1'bx};
      end
      chk("rx_byte", b, c[8 * i +: 8]);
    end
  endtask

  task automatic timer_run(input logic [31:0] n, input int len);
    int c;
    clr = 1'b1;
    N   = n;
    tick();
    chk("t_clr", t, 0);
    clr = 1'b0;
    c   = 0;
    #1;
    chk("t_release", t, (c >= n) ? 1 : 0);
    for (int i = 0; i < len; i++) begin
      tick();
      c = c + 1;
      chk("t_count", t, (c >= n) ? 1 : 0);
    end
    clr = 1'b1;
    #1;
    chk("t_reclr", t, 0);
  endtask

  initial begin
    logic [23:0] c1;
    logic [23:0] c2;
    logic [1:0]  nb2;
    int          nb;

    n_chk = 0; n_pass = 0;
    clear_mon();
    rst = 1'b1; clr = 1'b0; N = 32'd0; send = 1'b0; cmd = 24'd0; numbytes = 2'd0;
    tick();
    tick();
    chk("rst_t", t, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_sdo", sdo, 0);
    rst = 1'b0;
    #1;
    chk("t_n0_after_rst", t, 1);

    // Timer: directed N=5, then random terminal counts including 0.
    timer_run(32'd5, 10);
    for (int k = 0; k < 4; k++) timer_run(32'($urandom_range(0, 12)), 16);

    // Lowering N below the current count expires immediately.
    clr = 1'b1; N = 32'd10;
    tick();
    clr = 1'b0;
    repeat (6) tick();
    chk("t_before_lower", t, 0);
    N = 32'd3;
    #1;
    chk("t_lower_n", t, 1);
    clr = 1'b1;

    // SPI directed cases.
    start_xfer(1, 24'h0000A5);
    finish_xfer(1, 24'h0000A5, 0, 24'd0, 2'd0);
    tick();
    start_xfer(3, 24'h0F81AF);
    finish_xfer(3, 24'h0F81AF, 0, 24'd0, 2'd0);
    tick();

    // Random transfers.
    for (int k = 0; k < 6; k++) begin
      nb = $urandom_range(1, 3);
      c1 = 24'($urandom);
      start_xfer(nb, c1);
      finish_xfer(nb, c1, 0, 24'd0, 2'd0);
      repeat ($urandom_range(1, 3)) tick();
    end

    // send held high with cmd changed mid-flight: back-to-back transfers.
    c1  = 24'($urandom);
    c2  = 24'($urandom);
    nb2 = 2'($urandom_range(1, 3));
    start_xfer(3, c1);
    finish_xfer(3, c1, 1, c2, nb2);
    clear_mon();
    tick();
    chk("restart_rdy", rdy, 0);
    chk("restart_cs_n", cs_n, 0);
    chk("restart_sdo", sdo, c2[7]);
    finish_xfer(int'(nb2), c2, 0, 24'd0, 2'd0);
    tick();

    // Zero-byte request.
    clear_mon();
    send = 1'b1; numbytes = 2'd0; cmd = 24'hFFFFFF;
    tick();
    chk("zero_rdy_low", rdy, 0);
    chk("zero_cs_n", cs_n, 1);
    send = 1'b0;
    tick();
    chk("zero_rdy_back", rdy, 1);
    tick();
    chk("zero_cs_low", lo_cnt, 0);
    chk("zero_rises", rises, 0);

    // Reset mid-byte, then a clean transfer.
    c1 = 24'($urandom);
    start_xfer(1, c1);
    repeat (5) tick();
    send = 1'b0; clr = 1'b0; N = 32'd0;
    rst = 1'b1;
    #1;
    chk("arst_rdy", rdy, 1);
    chk("arst_cs_n", cs_n, 1);
    chk("arst_sclk", sclk, 1);
    chk("arst_sdo", sdo, 0);
    chk("arst_t", t, 0);
    tick();
    tick();
    rst = 1'b0;
    clr = 1'b1;
    tick();
    c2 = 24'($urandom);
    start_xfer(1, c2);
    finish_xfer(1, c2, 0, 24'd0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oled_spi_timer.md
# oled_spi_timer

Support core for the OLED command interpreter: one clock domain, two independent functions. A delay timer measures power-up and reset waits. A byte-serial SPI transmitter shifts 1–3 command/data bytes to the display. The interpreter clears and polls the timer, and drives the SPI transmitter with a level `send` / `rdy` handshake.

## Interface
- `SCLK_DIV`, default 10: SPI half-bit period in `clk` cycles; legal range ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  timer clear; holds the counter at 0 while high.
- `N`  in  32  timer terminal count, in cycles.
- `t`  out  1  timer expired.
- `numbytes`  in  2  bytes to send, 1–3.
- `cmd`  in  24  byte0 = `cmd[7:0]`, byte1 = `cmd[15:8]`, byte2 = `cmd[23:16]`.
- `send`  in  1  transfer request, level-sensitive.
- `rdy`  out  1  transmitter idle / able to accept.
- `sclk`  out  1  SPI clock; idles high.
- `sdo`  out  1  SPI data, MSB first.
- `cs_n`  out  1  active-low chip select.

## Operation
**Timer**
- 32-bit counter `cnt`.
- `clr`=1 → `cnt` ← 0.
- `clr`=0 and `cnt` < `N` → `cnt` ← `cnt`+1.
- Otherwise `cnt` holds (saturates).
- `t` = !`clr` && (`cnt` ≥ `N`), combinational.
- `t` stays high until the next `clr`.

**SPI transmitter** has states IDLE, LOW, HIGH.
- IDLE: `rdy`=1, `cs_n`=1, `sclk`=1, `sdo`=0.
  - If `send`=1, latch `cmd` and `numbytes`.
  - Set `rdy`←0 and `cs_n`←0, load bit 7 of byte0 onto `sdo`, set `sclk`←0, go to LOW.
  - `numbytes`=0: no shifting. `rdy`←0 for exactly one cycle, `cs_n` stays high, then back to IDLE.
- LOW: `sclk`=0 for `SCLK_DIV` cycles, then `sclk`←1 and go to HIGH. `sdo` is unchanged.
- HIGH: `sclk`=1 for `SCLK_DIV` cycles. Then:
  - If bits remain, drive the next bit on `sdo`, set `sclk`←0, go to LOW.
  - After the last bit of the last byte, set `cs_n`←1, `rdy`←1, `sdo`←0 and go to IDLE; `sclk` stays 1.
- Send order:
  - Bytes go byte0, byte1, byte2.
  - Bits within a byte go 7 down to 0.
  - Bytes are sent back-to-back with no gap and `cs_n` held low throughout.
- Data changes on `sclk` falling edges and is stable across rising edges (mode 3).
- `send` is ignored while `rdy`=0.
- `cmd` and `numbytes` changes after acceptance do not affect the transfer in flight.
- Master protocol:
  - Assert `send` only while `rdy`=1.
  - Deassert `send` after seeing `rdy`=0.
  - Treat completion as `rdy`=1 with `send`=0.
  - If `send` is still high when `rdy` returns, a new transfer starts on the next edge.
- Internal counters: a 3-bit bit index, a 2-bit byte index, and a ⌈log2(`SCLK_DIV`)⌉+1 bit phase counter.

## Timing
- Reset values, asserted immediately and held while `rst`=1:
  - `cnt`=0 and `t`=0, even if `clr`=0.
  - `rdy`=1, `cs_n`=1, `sclk`=1, `sdo`=0, state IDLE.
- Reset mid-transfer aborts it; the partial byte is lost.
- Timer: if `clr` falls before edge E, `t` rises after edge E+`N`−1, i.e. `N` cycles of `clr`=0.
  - `N`=0 → `t`=1 as soon as `clr`=0.
  - Lowering `N` below `cnt` makes `t` high immediately.
- SPI:
  - With `send` sampled high at edge k, `rdy`/`cs_n`/`sclk` all go low and the first `sdo` bit is valid at edge k.
  - Each bit occupies 2·`SCLK_DIV` cycles.
  - `cs_n` and `rdy` return high at edge k + 16·`SCLK_DIV`·`numbytes`.
  - At least one IDLE cycle separates transfers.

## Test plan
- Timer with `N`=5: release `clr` → `t` rises after exactly 5 edges and stays high. Reasserting `clr` → `t`=0 immediately.
- One byte, `SCLK_DIV`=2, `cmd[7:0]`=0xA5, `numbytes`=1:
  - `sdo` reads 1,0,1,0,0,1,0,1 at the 8 `sclk` rising edges.
  - `cs_n` is low for exactly 32 cycles.
  - `rdy` returns high with `cs_n`.
- Three bytes, `cmd`=0x0F_81_AF → bytes received in order 0xAF, 0x81, 0x0F with no `cs_n` gap; 48·`SCLK_DIV` cycles total.
- Hold `send`=1 through a transfer with `cmd` changed mid-flight → transfer is unaffected, and a second transfer starts one cycle after `rdy` returns.
- `numbytes`=0 → `rdy` low for one cycle, with no `sclk` edges and no `cs_n` activity.
- Assert `rst` mid-byte → all outputs reach reset values asynchronously. The next `send` transfers correctly from bit 7.
